// File: rtl/hid_report_accumulator.sv
// Keyboard/mouse report accumulator feeding the SPI HID status reply.
// Live state and saturating motion sums are frozen into a snapshot on each hid_read rise.
module hid_report_accumulator #(
  parameter int unsigned DELTA_WIDTH = 16,
  parameter int unsigned WHEEL_WIDTH = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    kbd_connected_in,
  input  logic                    kbd_report_valid,
  input  logic [7:0]              kbd_modifiers_in,
  input  logic [5:0][7:0]         kbd_keycodes_in,
  input  logic                    mouse_connected_in,
  input  logic                    mouse_report_valid,
  input  logic [7:0]              mouse_buttons_in,
  input  logic [DELTA_WIDTH-1:0]  mouse_dx_in,
  input  logic [DELTA_WIDTH-1:0]  mouse_dy_in,
  input  logic [WHEEL_WIDTH-1:0]  mouse_dwheel_in,
  input  logic                    hid_read,
  output logic                    hid_keyboard_connected,
  output logic                    hid_mouse_connected,
  output logic [7:0]              hid_keyboard_modifiers,
  output logic [5:0][7:0]         hid_keyboard_keycodes,
  output logic [7:0]              hid_mouse_buttons,
  output logic signed [31:0]      hid_mouse_x,
  output logic signed [31:0]      hid_mouse_y,
  output logic signed [31:0]      hid_mouse_wheel,
  output logic [7:0]              snapshot_seq
);

  typedef enum logic [1:0] {StIdle, StCapture, StHold} state_e;

  state_e state_q, state_d;
  logic   capture;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   rd_s, rd_q, armed_q, armed_d;

  logic             kbd_conn_q, mouse_conn_q;
  logic [7:0]       kbd_mod_q, kbd_mod_d;
  logic [5:0][7:0]  kbd_keys_q, kbd_keys_d;
  logic             rollover;
  logic [7:0]       btn_q, btn_d;
  logic signed [31:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_w_q, acc_w_d;
  logic signed [31:0] base_x, base_y, base_w;
  logic signed [31:0] dx_ext, dy_ext, dw_ext;

  logic             snap_kconn_q, snap_mconn_q;
  logic [7:0]       snap_mod_q, snap_btn_q, seq_q;
  logic [5:0][7:0]  snap_keys_q;
  logic signed [31:0] snap_x_q, snap_y_q, snap_w_q;

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] && !s[31]) begin
      return 32'sh8000_0000;
    end else if (!s[32] && s[31]) begin
      return 32'sh7FFF_FFFF;
    end
    return s[31:0];
  endfunction

  // hid_read synchroniser; fill_q marks when rd_s reflects a post-reset sample, so a
  // read already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      rd_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], hid_read};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      rd_q    <= rd_s;
      armed_q <= armed_d;
    end
  end

  assign rd_s    = sync_q[SYNC_STAGES-1];
  assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~rd_s);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle:    if (rd_s && !rd_q && armed_q) state_d = StCapture;
      StCapture: begin
        capture = 1'b1;
        state_d = StHold;
      end
      StHold:    if (!rd_s) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    kbd_mod_d  = kbd_mod_q;
    kbd_keys_d = kbd_keys_q;
    rollover   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rollover = rollover & (kbd_keycodes_in[i] == 8'h01);
    end
    if (kbd_report_valid) begin
      kbd_mod_d = kbd_modifiers_in;
      if (!rollover) kbd_keys_d = kbd_keycodes_in;
    end
    if (!kbd_connected_in) begin
      kbd_mod_d  = '0;
      kbd_keys_d = '0;
    end
  end

  assign dx_ext = 32'($signed(mouse_dx_in));
  assign dy_ext = 32'($signed(mouse_dy_in));
  assign dw_ext = 32'($signed(mouse_dwheel_in));

  // The capture cycle restarts the sums from zero so a same-cycle report lands after the clear.
  always_comb begin
    base_x  = capture ? 32'sd0 : acc_x_q;
    base_y  = capture ? 32'sd0 : acc_y_q;
    base_w  = capture ? 32'sd0 : acc_w_q;
    acc_x_d = base_x;
    acc_y_d = base_y;
    acc_w_d = base_w;
    btn_d   = btn_q;
    if (mouse_report_valid) begin
      acc_x_d = sat_add(base_x, dx_ext);
      acc_y_d = sat_add(base_y, dy_ext);
      acc_w_d = sat_add(base_w, dw_ext);
      btn_d   = mouse_buttons_in;
    end
    if (!mouse_connected_in) begin
      acc_x_d = '0;
      acc_y_d = '0;
      acc_w_d = '0;
      btn_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      kbd_conn_q   <= 1'b0;
      mouse_conn_q <= 1'b0;
      kbd_mod_q    <= '0;
      kbd_keys_q   <= '0;
      btn_q        <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      acc_w_q      <= '0;
    end else begin
      state_q      <= state_d;
      kbd_conn_q   <= kbd_connected_in;
      mouse_conn_q <= mouse_connected_in;
      kbd_mod_q    <= kbd_mod_d;
      kbd_keys_q   <= kbd_keys_d;
      btn_q        <= btn_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      acc_w_q      <= acc_w_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_kconn_q <= 1'b0;
      snap_mconn_q <= 1'b0;
      snap_mod_q   <= '0;
      snap_keys_q  <= '0;
      snap_btn_q   <= '0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
      snap_w_q     <= '0;
      seq_q        <= '0;
    end else if (capture) begin
      snap_kconn_q <= kbd_conn_q;
      snap_mconn_q <= mouse_conn_q;
      snap_mod_q   <= kbd_mod_q;
      snap_keys_q  <= kbd_keys_q;
      snap_btn_q   <= btn_q;
      snap_x_q     <= acc_x_q;
      snap_y_q     <= acc_y_q;
      snap_w_q     <= acc_w_q;
      seq_q        <= seq_q + 8'd1;
    end
  end

  // During the capture cycle the outputs already present the values being latched,
  // which brings the snapshot out one edge earlier than the snapshot registers alone.
  always_comb begin
    hid_keyboard_connected = capture ? kbd_conn_q   : snap_kconn_q;
    hid_mouse_connected    = capture ? mouse_conn_q : snap_mconn_q;
    hid_keyboard_modifiers = capture ? kbd_mod_q    : snap_mod_q;
    hid_keyboard_keycodes  = capture ? kbd_keys_q   : snap_keys_q;
    hid_mouse_buttons      = capture ? btn_q        : snap_btn_q;
    hid_mouse_x            = capture ? acc_x_q      : snap_x_q;
    hid_mouse_y            = capture ? acc_y_q      : snap_y_q;
    hid_mouse_wheel        = capture ? acc_w_q      : snap_w_q;
    snapshot_seq           = capture ? seq_q + 8'd1 : seq_q;
  end

endmodule

// File: tb/tb_hid_report_accumulator.sv
// Self-checking bench for hid_report_accumulator: table vectors, corner sequences and
// randomized reports checked against an arithmetic model of the snapshot contract.
module tb_hid_report_accumulator;
  localparam int DW = 24;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic reset;
  logic kbd_connected_in, kbd_report_valid, mouse_connected_in, mouse_report_valid, hid_read;
  logic [7:0] kbd_modifiers_in, mouse_buttons_in;
  logic [5:0][7:0] kbd_keycodes_in;
  logic [DW-1:0] mouse_dx_in, mouse_dy_in;
  logic [WW-1:0] mouse_dwheel_in;
  logic hid_keyboard_connected, hid_mouse_connected;
  logic [7:0] hid_keyboard_modifiers, hid_mouse_buttons, snapshot_seq;
  logic [5:0][7:0] hid_keyboard_keycodes;
  logic signed [31:0] hid_mouse_x, hid_mouse_y, hid_mouse_wheel;

  hid_report_accumulator #(.DELTA_WIDTH(DW), .WHEEL_WIDTH(WW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .kbd_connected_in(kbd_connected_in), .kbd_report_valid(kbd_report_valid),
    .kbd_modifiers_in(kbd_modifiers_in), .kbd_keycodes_in(kbd_keycodes_in),
    .mouse_connected_in(mouse_connected_in), .mouse_report_valid(mouse_report_valid),
    .mouse_buttons_in(mouse_buttons_in), .mouse_dx_in(mouse_dx_in),
    .mouse_dy_in(mouse_dy_in), .mouse_dwheel_in(mouse_dwheel_in), .hid_read(hid_read),
    .hid_keyboard_connected(hid_keyboard_connected), .hid_mouse_connected(hid_mouse_connected),
    .hid_keyboard_modifiers(hid_keyboard_modifiers), .hid_keyboard_keycodes(hid_keyboard_keycodes),
    .hid_mouse_buttons(hid_mouse_buttons), .hid_mouse_x(hid_mouse_x), .hid_mouse_y(hid_mouse_y),
    .hid_mouse_wheel(hid_mouse_wheel), .snapshot_seq(snapshot_seq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: live state and the last snapshot.
  longint mx, my, mw;
  logic [7:0] mbtn, kmod;
  logic [5:0][7:0] kkeys;
  longint s_x, s_y, s_w;
  logic [7:0] s_btn, s_mod;
  logic [5:0][7:0] s_keys;
  logic s_kc, s_mc;
  int mseq;

  typedef struct {
    int nrep; int dx0; int dx1; int dx2; int dy; longint ex; longint ey; int eseq;
  } vec_t;
  vec_t tbl[4];

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_x"}, longint'(hid_mouse_x), s_x);
    check({tag, "_y"}, longint'(hid_mouse_y), s_y);
    check({tag, "_w"}, longint'(hid_mouse_wheel), s_w);
    check({tag, "_btn"}, longint'(hid_mouse_buttons), longint'(s_btn));
    check({tag, "_mod"}, longint'(hid_keyboard_modifiers), longint'(s_mod));
    check({tag, "_keys"}, longint'(hid_keyboard_keycodes), longint'(s_keys));
    check({tag, "_seq"}, longint'(snapshot_seq), longint'(mseq));
    check({tag, "_kconn"}, longint'(hid_keyboard_connected), longint'(s_kc));
    check({tag, "_mconn"}, longint'(hid_mouse_connected), longint'(s_mc));
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mw = 0; mbtn = '0; kmod = '0; kkeys = '0;
    s_x = 0; s_y = 0; s_w = 0; s_btn = '0; s_mod = '0; s_keys = '0;
    s_kc = 1'b0; s_mc = 1'b0; mseq = 0;
  endtask

  task automatic model_snapshot();
    mseq = (mseq + 1) % 256;
    s_x = mx; s_y = my; s_w = mw; s_btn = mbtn; s_mod = kmod; s_keys = kkeys;
    s_kc = kbd_connected_in; s_mc = mouse_connected_in;
    mx = 0; my = 0; mw = 0;
  endtask

  // n back-to-back mouse reports with identical fields.
  task automatic mouse_burst(input int n, input int dx, input int dy, input int dw,
                             input logic [7:0] btn);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mouse_report_valid = 1'b1;
      mouse_dx_in = dx[DW-1:0];
      mouse_dy_in = dy[DW-1:0];
      mouse_dwheel_in = dw[WW-1:0];
      mouse_buttons_in = btn;
      if (mouse_connected_in) begin
        mx = clamp32(mx + dx); my = clamp32(my + dy); mw = clamp32(mw + dw); mbtn = btn;
      end
    end
    @(negedge clk);
    mouse_report_valid = 1'b0;
  endtask

  task automatic kbd_rep(input logic [7:0] m, input logic [5:0][7:0] k);
    @(negedge clk);
    kbd_report_valid = 1'b1;
    kbd_modifiers_in = m;
    kbd_keycodes_in = k;
    if (kbd_connected_in) begin
      kmod = m;
      if (k != {6{8'h01}}) kkeys = k;
    end
    @(negedge clk);
    kbd_report_valid = 1'b0;
  endtask

  // Raise hid_read; the snapshot must be visible 3 edges later and stay put.
  task automatic read_rise(input string tag);
    @(negedge clk);
    hid_read = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_snapshot();
    check_all(tag);
    repeat (2) @(posedge clk);
    #1;
    check_all({tag, "_held"});
  endtask

  task automatic read_fall();
    @(negedge clk);
    hid_read = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    hid_read = 1'b0;
    kbd_connected_in = 1'b1;
    mouse_connected_in = 1'b1;
    kbd_report_valid = 1'b0;
    mouse_report_valid = 1'b0;
    kbd_modifiers_in = '0;
    kbd_keycodes_in = '0;
    mouse_buttons_in = '0;
    mouse_dx_in = '0;
    mouse_dy_in = '0;
    mouse_dwheel_in = '0;
    model_reset();

    tbl[0] = '{3, 10, -3, 100, -5, 107, -15, 1};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 2};
    tbl[2] = '{3, 8388607, 8388607, -1, -8388608, 16777213, -25165824, 3};
    tbl[3] = '{2, -1000, 1000, 0, 3, 0, 6, 4};

    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int r = 0; r < tbl[v].nrep; r++) begin
        mouse_burst(1, (r == 0) ? tbl[v].dx0 : (r == 1) ? tbl[v].dx1 : tbl[v].dx2,
                    tbl[v].dy, 0, 8'h00);
      end
      read_rise("tbl");
      check("tbl_x_const", longint'(hid_mouse_x), tbl[v].ex);
      check("tbl_y_const", longint'(hid_mouse_y), tbl[v].ey);
      check("tbl_seq_const", longint'(snapshot_seq), longint'(tbl[v].eseq));
      read_fall();
    end

    // Reports during HOLD do not disturb the frozen snapshot.
    read_rise("hold_pre");
    mouse_burst(1, 50, 0, 0, 8'h01);
    repeat (3) @(negedge clk);
    check_all("hold_frozen");
    read_fall();
    read_rise("hold_post");
    check("hold_post_x_const", longint'(hid_mouse_x), 50);
    read_fall();

    // Saturation at both rails, then stepping back off the rail.
    mouse_burst(260, 8388607, -8388608, 0, 8'h00);
    read_rise("sat");
    check("sat_x_const", longint'(hid_mouse_x), 64'sd2147483647);
    check("sat_y_const", longint'(hid_mouse_y), -64'sd2147483648);
    read_fall();
    mouse_burst(260, 8388607, -8388608, 0, 8'h00);
    mouse_burst(1, -5, 5, 0, 8'h00);
    read_rise("sat_back");
    check("sat_back_x_const", longint'(hid_mouse_x), 64'sd2147483642);
    check("sat_back_y_const", longint'(hid_mouse_y), -64'sd2147483643);
    read_fall();

    // ErrorRollOver updates modifiers only.
    kbd_rep(8'h02, {8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h04});
    kbd_rep(8'h00, {6{8'h01}});
    read_rise("rollover");
    check("rollover_mod_const", longint'(hid_keyboard_modifiers), 0);
    check("rollover_key0_const", longint'(hid_keyboard_keycodes[0]), 4);
    check("rollover_key1_const", longint'(hid_keyboard_keycodes[1]), 5);
    read_fall();

    // Mouse report landing exactly in the capture cycle.
    mouse_burst(1, 20, 0, 0, 8'h02);
    @(negedge clk);
    hid_read = 1'b1;
    repeat (3) @(negedge clk);
    mouse_report_valid = 1'b1;
    mouse_dx_in = 24'd7;
    mouse_dy_in = '0;
    mouse_dwheel_in = '0;
    mouse_buttons_in = 8'h02;
    model_snapshot();
    mx = 7;
    @(negedge clk);
    mouse_report_valid = 1'b0;
    check_all("capx");
    check("capx_x_const", longint'(hid_mouse_x), 20);
    read_fall();
    read_rise("capx_next");
    check("capx_next_x_const", longint'(hid_mouse_x), 7);
    read_fall();

    // Disconnect clears live mouse state and ignores reports.
    mouse_burst(1, 33, 1, 1, 8'h05);
    @(negedge clk);
    mouse_connected_in = 1'b0;
    mx = 0; my = 0; mw = 0; mbtn = '0;
    mouse_burst(1, 44, 2, 2, 8'h06);
    repeat (2) @(negedge clk);
    read_rise("disc");
    read_fall();
    mouse_connected_in = 1'b1;
    repeat (2) @(negedge clk);

    for (int it = 0; it < 30; it++) begin
      int n;
      logic [DW-1:0] rx, ry;
      logic [WW-1:0] rw;
      logic [5:0][7:0] k;
      n = int'($urandom_range(0, 4));
      for (int r = 0; r < n; r++) begin
        rx = DW'($urandom);
        ry = DW'($urandom);
        rw = WW'($urandom);
        mouse_burst(1, int'($signed(rx)), int'($signed(ry)), int'($signed(rw)),
                    8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        k = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) k = {6{8'h01}};
        kbd_rep(8'($urandom), k);
      end
      read_rise("rand");
      read_fall();
    end

    // Reset while holding a nonzero snapshot, released with hid_read still high.
    mouse_burst(1, 123, -45, 6, 8'h09);
    read_rise("pre_rst");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    mouse_burst(1, 9, 0, 0, 8'h03);
    repeat (6) @(negedge clk);
    check_all("no_recap");
    read_fall();
    read_rise("post_rst");
    check("post_rst_x_const", longint'(hid_mouse_x), 9);
    check("post_rst_seq_const", longint'(snapshot_seq), 1);
    read_fall();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
